// File: rtl/unique_serializer.sv
// unique_serializer: takes one group of activations plus repetition info and
// emits each unique non-zero activation, with its duplicate mask, one per cycle.
module unique_serializer #(
  parameter  int unsigned GROUP_SIZE     = 4,
  parameter  int unsigned DATA_WIDTH     = 8,
  parameter  int unsigned LOG_MAX_GROUPS = 16,
  localparam int unsigned IN_WIDTH       = GROUP_SIZE*DATA_WIDTH + GROUP_SIZE*GROUP_SIZE + GROUP_SIZE,
  localparam int unsigned OUT_WIDTH      = DATA_WIDTH + GROUP_SIZE + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      configure,
  input  logic [LOG_MAX_GROUPS-1:0] num_groups,
  input  logic [IN_WIDTH-1:0]       data_in,
  input  logic                      valid_in,
  output logic                      avail_out,
  output logic [OUT_WIDTH-1:0]      data_out,
  output logic                      valid_out,
  input  logic                      avail_in,
  output logic                      done
);

  localparam int unsigned ACT_W = GROUP_SIZE*DATA_WIDTH;
  localparam int unsigned REP_W = GROUP_SIZE*GROUP_SIZE;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                                   state_q, state_d;
  logic                                     enabled_q, enabled_d;
  logic [LOG_MAX_GROUPS-1:0]                cnt_q, cnt_d;
  logic [GROUP_SIZE-1:0]                    pending_q, pending_d;
  logic                                     done_q, done_d;
  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    act_q;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]    rep_q;
  logic                                     capture;

  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    act_in;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]    rep_in;
  logic [GROUP_SIZE-1:0]                    zero_in;
  logic [GROUP_SIZE-1:0]                    diag_in;

  logic [GROUP_SIZE-1:0]                    sel_oh;
  logic [GROUP_SIZE-1:0]                    rest;
  logic                                     last_c;
  logic [DATA_WIDTH-1:0]                    value_c;
  logic [GROUP_SIZE-1:0]                    mask_c;

  // Unpack the incoming group: activations, rep_info rows, zero flags.
  always_comb begin
    act_in  = data_in[ACT_W-1:0];
    rep_in  = data_in[ACT_W +: REP_W];
    zero_in = data_in[ACT_W+REP_W +: GROUP_SIZE];
    diag_in = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      diag_in[i] = rep_in[i][i];
    end
  end

  // Lowest pending element is the one emitted; an empty pending set yields the zero token.
  always_comb begin
    sel_oh  = pending_q & (~pending_q + GROUP_SIZE'(1));
    rest    = pending_q & ~sel_oh;
    last_c  = (rest == '0);
    value_c = '0;
    mask_c  = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (sel_oh[i]) begin
        value_c = act_q[i];
        mask_c  = rep_q[i];
      end
    end
  end

  assign avail_out = enabled_q && (state_q == IDLE);
  assign valid_out = (state_q == EMIT) && avail_in && !configure;
  assign data_out  = (state_q == EMIT) ? {last_c, mask_c, value_c} : '0;
  assign done      = done_q;

  // Next-state logic: configure wins over capture and emission.
  always_comb begin
    state_d   = state_q;
    enabled_d = enabled_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    capture   = 1'b0;
    if (configure) begin
      state_d   = IDLE;
      pending_d = '0;
      cnt_d     = num_groups;
      enabled_d = (num_groups != '0);
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in && enabled_q) begin
            capture   = 1'b1;
            pending_d = diag_in & ~zero_in;
            state_d   = EMIT;
          end
        end
        EMIT: begin
          if (avail_in) begin
            pending_d = pending_q & ~sel_oh;
            if (last_c) begin
              state_d = IDLE;
              if (cnt_q != '0) begin
                cnt_d = cnt_q - LOG_MAX_GROUPS'(1);
              end
              if (cnt_q == LOG_MAX_GROUPS'(1)) begin
                enabled_d = 1'b0;
                done_d    = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      enabled_q <= 1'b0;
      cnt_q     <= '0;
      pending_q <= '0;
      done_q    <= 1'b0;
      act_q     <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      enabled_q <= enabled_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      if (capture) begin
        act_q <= act_in;
        rep_q <= rep_in;
      end
    end
  end

endmodule

// File: tb/tb_unique_serializer.sv
// Directed bench for unique_serializer (GROUP_SIZE=4, DATA_WIDTH=8).
module tb_unique_serializer;

  logic        clk;
  logic        rst;
  logic        configure;
  logic [15:0] num_groups;
  logic [51:0] data_in;
  logic        valid_in;
  logic        avail_out;
  logic [12:0] data_out;
  logic        valid_out;
  logic        avail_in;
  logic        done;

  int tests;
  int fails;

  unique_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .configure  (configure),
    .num_groups (num_groups),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .avail_out  (avail_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .avail_in   (avail_in),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack a group: activations a0..a3, rep rows r0..r3, zero flags z.
  function automatic logic [51:0] mk(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3,
                                     input logic [3:0] r0, input logic [3:0] r1,
                                     input logic [3:0] r2, input logic [3:0] r3,
                                     input logic [3:0] z);
    mk = {z, r3, r2, r1, r0, a3, a2, a1, a0};
  endfunction

  // Pulse configure for one cycle; returns on the following falling edge.
  task automatic do_config(input logic [15:0] n);
    @(negedge clk);
    configure  = 1'b1;
    num_groups = n;
    valid_in   = 1'b0;
    @(negedge clk);
    configure  = 1'b0;
  endtask

  // Offer one group in the current cycle and check it is accepted.
  task automatic offer(input logic [51:0] g, input string name);
    valid_in = 1'b1;
    data_in  = g;
    avail_in = 1'b1;
    #1;
    tests++;
    if (avail_out !== 1'b1) begin
      fails++;
      $display("FAIL %s_avail: got avail_out=%0b want 1", name, avail_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; configure = 1'b0; num_groups = '0; data_in = '0;
    valid_in = 1'b1; avail_in = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (avail_out !== 1'b0 || valid_out !== 1'b0 || done !== 1'b0 || data_out !== 13'h0) begin
      fails++;
      $display("FAIL reset: got av=%0b vo=%0b done=%0b data=%h want 0 0 0 0",
               avail_out, valid_out, done, data_out);
    end
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (avail_out !== 1'b0 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got av=%0b vo=%0b want 0 0", avail_out, valid_out);
    end
  endtask

  task automatic test_dup_group();
    do_config(16'd1);
    offer(mk(8'd3, 8'd2, 8'd3, 8'd3, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000), "dup");
    #1;
    tests++;
    if (valid_out !== 1'b1 || data_out !== {1'b0, 4'b1101, 8'd3} || avail_out !== 1'b0) begin
      fails++;
      $display("FAIL dup_item0: got vo=%0b data=%h av=%0b want 1 %h 0",
               valid_out, data_out, avail_out, {1'b0, 4'b1101, 8'd3});
    end
    @(negedge clk);
    #1;
    tests++;
    if (valid_out !== 1'b1 || data_out !== {1'b1, 4'b0010, 8'd2} || done !== 1'b0) begin
      fails++;
      $display("FAIL dup_item1: got vo=%0b data=%h done=%0b want 1 %h 0",
               valid_out, data_out, done, {1'b1, 4'b0010, 8'd2});
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || valid_out !== 1'b0 || avail_out !== 1'b0) begin
      fails++;
      $display("FAIL dup_done: got done=%0b vo=%0b av=%0b want 1 0 0", done, valid_out, avail_out);
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL dup_done_pulse: got done=%0b want 0", done);
    end
  endtask

  task automatic test_zero_elems();
    do_config(16'd1);
    offer(mk(8'd0, 8'd5, 8'd0, 8'd5, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 4'b0101), "zel");
    #1;
    tests++;
    if (valid_out !== 1'b1 || data_out !== {1'b1, 4'b1010, 8'd5}) begin
      fails++;
      $display("FAIL zero_elem_item: got vo=%0b data=%h want 1 %h",
               valid_out, data_out, {1'b1, 4'b1010, 8'd5});
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL zero_elem_done: got done=%0b vo=%0b want 1 0", done, valid_out);
    end
  endtask

  task automatic test_all_zero();
    do_config(16'd1);
    offer(mk(8'd0, 8'd0, 8'd0, 8'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111), "az");
    #1;
    tests++;
    if (valid_out !== 1'b1 || data_out !== {1'b1, 4'b0000, 8'd0}) begin
      fails++;
      $display("FAIL all_zero_token: got vo=%0b data=%h want 1 %h",
               valid_out, data_out, {1'b1, 4'b0000, 8'd0});
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL all_zero_done: got done=%0b vo=%0b want 1 0", done, valid_out);
    end
  endtask

  task automatic test_stall();
    logic [5:0]  av_pat;
    logic [12:0] exp_d [6];
    av_pat   = 6'b111001;  // bit k is avail_in on emit cycle k
    exp_d[0] = {1'b0, 4'b0001, 8'd1};
    exp_d[1] = {1'b0, 4'b0010, 8'd2};
    exp_d[2] = {1'b0, 4'b0010, 8'd2};
    exp_d[3] = {1'b0, 4'b0010, 8'd2};
    exp_d[4] = {1'b0, 4'b0100, 8'd3};
    exp_d[5] = {1'b1, 4'b1000, 8'd4};
    do_config(16'd1);
    offer(mk(8'd1, 8'd2, 8'd3, 8'd4, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000), "stall");
    for (int k = 0; k < 6; k++) begin
      avail_in = av_pat[k];
      #1;
      tests++;
      if (valid_out !== av_pat[k] || data_out !== exp_d[k] || done !== 1'b0) begin
        fails++;
        $display("FAIL stall_cyc%0d: got vo=%0b data=%h done=%0b want %0b %h 0",
                 k, valid_out, data_out, done, av_pat[k], exp_d[k]);
      end
      @(negedge clk);
    end
    avail_in = 1'b1;
    #1;
    tests++;
    if (done !== 1'b1 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL stall_done: got done=%0b vo=%0b want 1 0", done, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_d [6];
    logic [5:0]  exp_vo;
    logic [5:0]  exp_av;
    logic [5:0]  exp_dn;
    exp_d[0] = 13'h0;
    exp_d[1] = {1'b0, 4'b1101, 8'd3};
    exp_d[2] = {1'b1, 4'b0010, 8'd2};
    exp_d[3] = 13'h0;
    exp_d[4] = {1'b0, 4'b1101, 8'd3};
    exp_d[5] = {1'b1, 4'b0010, 8'd2};
    exp_vo = 6'b110110;
    exp_av = 6'b001001;
    exp_dn = 6'b000000;
    do_config(16'd2);
    valid_in = 1'b1;
    avail_in = 1'b1;
    data_in  = mk(8'd3, 8'd2, 8'd3, 8'd3, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      #1;
      tests++;
      if (valid_out !== exp_vo[k] || avail_out !== exp_av[k] || done !== exp_dn[k] ||
          data_out !== exp_d[k]) begin
        fails++;
        $display("FAIL b2b_cyc%0d: got vo=%0b av=%0b done=%0b data=%h want %0b %0b %0b %h",
                 k, valid_out, avail_out, done, data_out, exp_vo[k], exp_av[k], exp_dn[k], exp_d[k]);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (done !== 1'b1 || avail_out !== 1'b0 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: got done=%0b av=%0b vo=%0b want 1 0 0", done, avail_out, valid_out);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      tests++;
      if (done !== 1'b0 || avail_out !== 1'b0 || valid_out !== 1'b0) begin
        fails++;
        $display("FAIL b2b_ignored%0d: got done=%0b av=%0b vo=%0b want 0 0 0",
                 k, done, avail_out, valid_out);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_abort();
    do_config(16'd1);
    offer(mk(8'd1, 8'd2, 8'd3, 8'd4, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000), "abort");
    configure  = 1'b1;
    num_groups = 16'd1;
    valid_in   = 1'b1;
    #1;
    tests++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_valid: got vo=%0b want 0", valid_out);
    end
    @(negedge clk);
    configure = 1'b0;
    valid_in  = 1'b0;
    #1;
    tests++;
    if (avail_out !== 1'b1 || valid_out !== 1'b0 || done !== 1'b0 || data_out !== 13'h0) begin
      fails++;
      $display("FAIL abort_idle: got av=%0b vo=%0b done=%0b data=%h want 1 0 0 0",
               avail_out, valid_out, done, data_out);
    end
    do_config(16'd0);
    #1;
    tests++;
    if (avail_out !== 1'b0) begin
      fails++;
      $display("FAIL cfg_zero_avail: got av=%0b want 0", avail_out);
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || avail_out !== 1'b0) begin
      fails++;
      $display("FAIL cfg_zero_done: got done=%0b av=%0b want 0 0", done, avail_out);
    end
  endtask

  task automatic test_reset_mid_emit();
    do_config(16'd1);
    offer(mk(8'd1, 8'd2, 8'd3, 8'd4, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000), "rme");
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (valid_out !== 1'b0 || data_out !== 13'h0 || avail_out !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_emit: got vo=%0b data=%h av=%0b done=%0b want 0 0 0 0",
               valid_out, data_out, avail_out, done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (valid_out !== 1'b0 || avail_out !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_stale: got vo=%0b av=%0b want 0 0", valid_out, avail_out);
    end
    do_config(16'd1);
    offer(mk(8'd7, 8'd7, 8'd7, 8'd7, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "sev");
    #1;
    tests++;
    if (valid_out !== 1'b1 || data_out !== {1'b1, 4'b1111, 8'd7}) begin
      fails++;
      $display("FAIL sevens_item: got vo=%0b data=%h want 1 %h",
               valid_out, data_out, {1'b1, 4'b1111, 8'd7});
    end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b1 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL sevens_done: got done=%0b vo=%0b want 1 0", done, valid_out);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_dup_group();
    test_zero_elems();
    test_all_zero();
    test_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unique_serializer.md
UNIQUE_SERIALIZER -- requirements
Module: unique_serializer

Interface
REQ-001 The block SHALL be a downstream consumer of repetition-detector output and SHALL emit one unique non-zero activation per cycle.
REQ-002 The block SHALL have the following parameters:
- GROUP_SIZE, default 4: elements per group.
- DATA_WIDTH, default 8: activation width.
- LOG_MAX_GROUPS, default 16: group counter width.
- IN_WIDTH, local = GROUP_SIZE*DATA_WIDTH + GROUP_SIZE*GROUP_SIZE + GROUP_SIZE.
- OUT_WIDTH, local = DATA_WIDTH + GROUP_SIZE + 1.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- configure  in  1  load num_groups, enable block.
- num_groups  in  LOG_MAX_GROUPS  groups to process before disabling.
- data_in  in  IN_WIDTH  [GS*DW-1:0] activations (element e at e*DW); next GS*GS bits rep_info (row i bit j at i*GS+j); top GS bits zero flags.
- valid_in  in  1  data_in valid.
- avail_out  out  1  block can accept a group this cycle.
- data_out  out  OUT_WIDTH  {last, mask[GS-1:0], value[DW-1:0]}.
- valid_out  out  1  data_out valid and consumed this cycle.
- avail_in  in  1  downstream can accept.
- done  out  1  one-cycle pulse after final item of final group.

Function
REQ-005 The block SHALL implement two states: IDLE (no group held) and EMIT (group held in registers).
REQ-006 avail_out SHALL equal enabled AND state==IDLE, combinationally.
REQ-007 On valid_in AND avail_out, the block SHALL register the activations, rep_info and zero flags, and SHALL go to EMIT.
REQ-008 valid_in while avail_out=0 SHALL be ignored, with no capture.
REQ-009 On capture, a GS-bit pending vector SHALL be formed: pending[i] = rep_info[i*GS+i] AND NOT zero[i].
REQ-010 Emission selection SHALL work as follows:
- In EMIT, sel = lowest set index of pending.
- value = activation[sel], mask[j] = rep_info[sel*GS+j], last = 1 iff sel is the only set bit.
REQ-011 valid_out SHALL equal (state==EMIT) AND avail_in, combinationally; data_out is defined whenever state==EMIT.
REQ-012 On each valid_out cycle, pending[sel] SHALL clear.
REQ-013 When last is emitted, the next state SHALL be IDLE; the earliest next capture is the following cycle.
REQ-014 A captured group with pending all-zero (all elements zero) SHALL emit exactly one token: value=0, mask=0, last=1.
REQ-015 Latency SHALL be: capture at cycle N gives first valid_out at N+1 if avail_in=1; a group with U uniques occupies U+1 cycles minimum, including capture.
REQ-016 avail_in=0 SHALL stall: held data, pending and data_out stay constant.
REQ-017 Group counting SHALL work as follows:
- configure loads group_cnt=num_groups and sets enabled=1.
- Each emitted last decrements group_cnt.
- When last is emitted with group_cnt==1: enabled=0, done=1 next cycle for one cycle, state to IDLE.
REQ-018 num_groups=0 with configure SHALL leave enabled=0, assert no done, and leave avail_out=0.
REQ-019 configure asserted during EMIT SHALL abort the held group: state to IDLE, pending cleared, no valid_out that cycle, counter reloaded.
REQ-020 configure SHALL take priority over simultaneous valid_in and valid_out.
REQ-021 The block SHALL assume rep_info is well-formed; each element SHALL appear in at most one emitted mask by construction.

Reset
REQ-022 Reset SHALL be asynchronous on rst low and SHALL force state=IDLE, enabled=0, group_cnt=0, pending=0, done=0.
REQ-023 During reset, the outputs SHALL be: avail_out=0, valid_out=0, done=0, data_out=0.
REQ-024 Reset asserted mid-EMIT SHALL drop the held group, and no further valid_out SHALL occur until configure and a new capture.

Verification
REQ-025 The bench SHALL cover configure num_groups=1, group 3,2,3,3 (element0=3), avail_in=1 -> two items are required:
- value 3, mask 4'b1101, last 0.
- value 2, mask 4'b0010, last 1.
- done pulses one cycle later.
REQ-026 The bench SHALL cover group 0,5,0,5 -> a single item is required: value 5, mask 4'b1010, last 1; the zero element is not emitted.
REQ-027 The bench SHALL cover group 0,0,0,0 -> one token: value 0, mask 0, last 1.
REQ-028 The bench SHALL cover group 1,2,3,4 with avail_in toggling 1,0,0,1,1,1 -> items 1,2,3,4 in order, each held stable while stalled, with last only on 4.
REQ-029 The bench SHALL cover num_groups=2, valid_in held high continuously -> avail_out=0 during EMIT; the second group is captured the cycle after the first group's last; enabled clears after the second group's last; further valid_in is ignored.
REQ-030 The bench SHALL cover rst low mid-EMIT, then configure num_groups=1 and group 7,7,7,7 -> no stale output; a single item is required: value 7, mask 4'b1111, last 1.
